multicycle_ctrl: RTL

- Multi-cycle RV32I control FSM that drives the PC update unit.
- Sequences FETCH/DECODE/EXEC/MEM/WB for each instruction and produces `pc_load`, `pc_src`, the branch-select mask and the polarity-corrected condition bus consumed by the PC updater.
- Also drives instruction-register, memory and register-file strobes, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM driving the PC updater
module multicycle_ctrl #(
   parameter logic [2:0] RESET_STATE = 3'd0,
   parameter int         CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [31:0]      instr,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             alu_eq,
   input  logic             alu_lt,
   input  logic             alu_ltu,
   output logic             imem_req,
   output logic             ir_load,
   output logic             dmem_re,
   output logic             dmem_we,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             pc_load,
   output logic [1:0]       pc_src,
   output logic [2:0]       branch,
   output logic [2:0]       zero,
   output logic [2:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);
   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   logic [2:0]       state_q, state_d;
   logic [6:0]       op_q;
   logic [2:0]       f3_q;
   logic             illegal_q;
   logic [CNT_W-1:0] instret_q;

   logic is_br, is_ld, is_st, legal;

   assign is_br = (op_q == OP_BR);
   assign is_ld = (op_q == OP_LOAD);
   assign is_st = (op_q == OP_STORE);

   always_comb begin
      legal = 1'b0;
      case (op_q)
         OP_REG, OP_IMM, OP_LUI, OP_AUIPC,
         OP_LOAD, OP_STORE, OP_JAL, OP_JALR: legal = 1'b1;
         OP_BR:                              legal = (f3_q[2:1] != 2'b01);
         default:                            legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:  if (imem_ready) state_d = ST_DECODE;
         ST_DECODE: state_d = legal ? ST_EXEC : ST_TRAP;
         ST_EXEC: begin
            if (is_br)              state_d = ST_FETCH;
            else if (is_ld | is_st) state_d = ST_MEM;
            else                    state_d = ST_WB;
         end
         ST_MEM:    if (dmem_ready) state_d = is_ld ? ST_WB : ST_FETCH;
         ST_WB:     state_d = ST_FETCH;
         ST_TRAP:   state_d = ST_TRAP;
         default:   state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      imem_req = 1'b0;
      ir_load  = 1'b0;
      dmem_re  = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = 2'd0;
      pc_load  = 1'b0;
      pc_src   = 2'd0;
      branch   = 3'b000;
      case (state_q)
         ST_FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ready;
         end
         ST_EXEC: begin
            if (is_br) begin
               pc_load = 1'b1;
               case (f3_q[2:1])
                  2'b00:   branch = 3'b100;
                  2'b10:   branch = 3'b010;
                  2'b11:   branch = 3'b001;
                  default: branch = 3'b000;
               endcase
            end
         end
         ST_MEM: begin
            dmem_re = is_ld;
            dmem_we = is_st;
            pc_load = is_st & dmem_ready;
         end
         ST_WB: begin
            rf_we   = 1'b1;
            pc_load = 1'b1;
            case (op_q)
               OP_LOAD: wb_sel = 2'd1;
               OP_JAL:  begin wb_sel = 2'd2; pc_src = 2'd1; end
               OP_JALR: begin wb_sel = 2'd2; pc_src = 2'd2; end
               default: wb_sel = 2'd0;
            endcase
         end
         default: ;
      endcase
   end

   // Opcode/funct3 latch, trap flag and retirement counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_q      <= 7'd0;
         f3_q      <= 3'd0;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         if (ir_load) begin
            op_q <= instr[6:0];
            f3_q <= instr[14:12];
         end
         if (state_d == ST_TRAP) illegal_q <= 1'b1;
         if (pc_load) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Odd funct3 selects the inverted sense (bne/bge/bgeu)
   assign zero    = {alu_eq, alu_lt, alu_ltu} ^ {3{f3_q[0]}};
   assign state   = state_q;
   assign illegal = illegal_q;
   assign instret = instret_q;
endmodule
